// File: rtl/counter_pkg.sv
// counter_pkg: shared counter mode and direction definitions
package counter_pkg;
  typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: emits one tick every PRESCALE enabled cycles; clr restarts the phase
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic enable,
  output logic tick
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] cnt;
  // with PRESCALE=1 cnt never leaves 0, so tick follows enable
  assign tick = enable && (cnt == PW'(PRESCALE - 1));
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/param_up_down_counter.sv
// param_up_down_counter: prescaled up/down counter with wrap/saturate, load/clear and event pulses
module param_up_down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int MAX_VAL = 7,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             direction,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             overflow,
  output logic             underflow
);
  localparam cnt_mode_e MODE = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;
  localparam logic [WIDTH:0] MAX_W = (WIDTH + 1)'(MAX_VAL);
  localparam logic [WIDTH:0] MOD_W = (WIDTH + 1)'(MAX_VAL + 1);
  logic tick, ovf_c, udf_c, nxt_ovf, nxt_udf;
  logic [WIDTH:0] cnt_w, stp_w, ld_w, sum, up_nxt, dn_nxt;
  logic [WIDTH-1:0] nxt;
  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clock,
    .reset_n,
    .clr(clear | load),
    .enable,
    .tick
  );
  // one extra bit keeps carries and borrows visible before folding back into range
  always_comb begin
    cnt_w = {1'b0, count};
    stp_w = {1'b0, step};
    ld_w = {1'b0, load_val};
    sum = cnt_w + stp_w;
    ovf_c = sum > MAX_W;
    udf_c = stp_w > cnt_w;
    up_nxt = !ovf_c ? sum : (MODE == CNT_SAT) ? MAX_W : sum - MOD_W;
    dn_nxt = !udf_c ? cnt_w - stp_w : (MODE == CNT_SAT) ? '0 : cnt_w + MOD_W - stp_w;
    nxt = WIDTH'(clear ? '0 : load ? (ld_w > MAX_W ? MAX_W : ld_w) :
                 !tick ? cnt_w : (direction == DIR_UP) ? up_nxt : dn_nxt);
    nxt_ovf = !clear && !load && tick && (direction == DIR_UP) && ovf_c;
    nxt_udf = !clear && !load && tick && (direction == DIR_DOWN) && udf_c;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count <= nxt;
      overflow <= nxt_ovf;
      underflow <= nxt_udf;
    end
  assign at_max = count == WIDTH'(MAX_VAL);
  assign at_min = count == '0;
  a_step_legal: assert property (@(posedge clock) disable iff (!reset_n) tick |-> stp_w <= MAX_W);
endmodule

// File: tb/tb_param_up_down_counter.sv
// tb_param_up_down_counter: directed checks on wrap, saturate, modulus-6 and prescaled variants
module tb_param_up_down_counter;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic clear, load, enable, direction;
  logic [3:0] load_val, step;
  logic [2:0] w_count, s_count, p_count;
  logic [3:0] m_count;
  logic w_max, w_min, w_ovf, w_udf;
  logic s_max, s_min, s_ovf, s_udf;
  logic m_max, m_min, m_ovf, m_udf;
  logic p_max, p_min, p_ovf, p_udf;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  param_up_down_counter #(.WIDTH(3), .MAX_VAL(7), .SATURATE(0), .PRESCALE(1)) u_wrap (
    .clock(clock), .reset_n(reset_n), .clear(clear), .load(load), .load_val(load_val[2:0]),
    .enable(enable), .direction(direction), .step(step[2:0]), .count(w_count),
    .at_max(w_max), .at_min(w_min), .overflow(w_ovf), .underflow(w_udf));
  param_up_down_counter #(.WIDTH(3), .MAX_VAL(7), .SATURATE(1), .PRESCALE(1)) u_sat (
    .clock(clock), .reset_n(reset_n), .clear(clear), .load(load), .load_val(load_val[2:0]),
    .enable(enable), .direction(direction), .step(step[2:0]), .count(s_count),
    .at_max(s_max), .at_min(s_min), .overflow(s_ovf), .underflow(s_udf));
  param_up_down_counter #(.WIDTH(4), .MAX_VAL(5), .SATURATE(0), .PRESCALE(1)) u_mod6 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .load(load), .load_val(load_val),
    .enable(enable), .direction(direction), .step(step), .count(m_count),
    .at_max(m_max), .at_min(m_min), .overflow(m_ovf), .underflow(m_udf));
  param_up_down_counter #(.WIDTH(3), .MAX_VAL(7), .SATURATE(0), .PRESCALE(3)) u_pre (
    .clock(clock), .reset_n(reset_n), .clear(clear), .load(load), .load_val(load_val[2:0]),
    .enable(enable), .direction(direction), .step(step[2:0]), .count(p_count),
    .at_max(p_max), .at_min(p_min), .overflow(p_ovf), .underflow(p_udf));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear = 0; load = 0; load_val = 0; enable = 0; direction = 1; step = 1;
    repeat (2) cyc();
    reset_n = 1;
    check("rst_count", w_count, 0);
    check("rst_at_min", w_min, 1);
    check("rst_at_max", w_max, 0);
    check("rst_ovf", w_ovf, 0);
    check("rst_udf", w_udf, 0);
    check("rst_m_at_max", m_max, 0);
    // wrap up through 7 -> 0, then one step down from 0
    enable = 1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      check("wrap_up_count", w_count, i % 8);
      if (i == 7) begin
        check("wrap_at_max", w_max, 1);
        check("wrap_no_ovf_yet", w_ovf, 0);
      end
      if (i == 8) check("wrap_ovf", w_ovf, 1);
    end
    direction = 0;
    cyc();
    check("wrap_down_count", w_count, 7);
    check("wrap_udf", w_udf, 1);
    check("wrap_ovf_cleared", w_ovf, 0);
    enable = 0;
    cyc();
    check("hold_count", w_count, 7);
    check("hold_udf_low", w_udf, 0);
    // saturating instance
    load_val = 6; load = 1;
    cyc();
    load = 0;
    check("sat_load", s_count, 6);
    step = 3; direction = 1; enable = 1;
    cyc();
    check("sat_up_count", s_count, 7);
    check("sat_up_ovf", s_ovf, 1);
    cyc();
    check("sat_again_count", s_count, 7);
    check("sat_again_ovf", s_ovf, 1);
    step = 0;
    cyc();
    check("sat_step0_count", s_count, 7);
    check("sat_step0_ovf", s_ovf, 0);
    enable = 0; load_val = 2; load = 1;
    cyc();
    load = 0;
    check("sat_load2", s_count, 2);
    check("sat_load_no_pulse", s_ovf, 0);
    step = 5; direction = 0; enable = 1;
    cyc();
    enable = 0;
    check("sat_down_count", s_count, 0);
    check("sat_down_udf", s_udf, 1);
    // wrap arithmetic and load clamp
    load_val = 5; load = 1;
    cyc();
    load = 0; step = 3; direction = 1; enable = 1;
    cyc();
    enable = 0;
    check("wrap5p3_count", w_count, 0);
    check("wrap5p3_ovf", w_ovf, 1);
    load_val = 9; load = 1;
    cyc();
    load = 0;
    check("m6_load_clamp", m_count, 5);
    check("m6_at_max", m_max, 1);
    load_val = 4; load = 1;
    cyc();
    load = 0; enable = 1;
    cyc();
    enable = 0;
    check("m6_wrap_count", m_count, 1);
    check("m6_wrap_ovf", m_ovf, 1);
    // prescale by 3
    clear = 1;
    cyc();
    clear = 0; step = 1; direction = 1; enable = 1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      check("pre_count", p_count, i / 3);
    end
    enable = 0;
    repeat (2) cyc();
    check("pre_hold", p_count, 3);
    enable = 1;
    cyc();
    check("pre_resume1", p_count, 3);
    cyc();
    check("pre_resume2", p_count, 4);
    clear = 1; load = 1; load_val = 5;
    cyc();
    clear = 0; load = 0;
    check("pre_clear_beats_load", p_count, 0);
    repeat (2) cyc();
    check("pre_phase_reset", p_count, 0);
    cyc();
    check("pre_first_tick", p_count, 1);
    // async reset between edges
    clear = 1;
    cyc();
    clear = 0;
    repeat (4) cyc();
    check("mid_count", w_count, 4);
    #2 reset_n = 0;
    #1;
    check("async_rst_count", w_count, 0);
    check("async_rst_at_min", w_min, 1);
    #2 reset_n = 1;
    cyc();
    check("resume_count", w_count, 1);
    enable = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
